operand_issue_stage: RTL and testbench

//   Decode-to-execute issue stage: drives register-file read addresses, collects
//   the two source operands, and registers them into the ID/EX pipeline slot.

---
 rtl/operand_issue_stage_if.sv | 42 ++++
 rtl/operand_issue_stage.sv | 106 ++++++++++
 tb/tb_operand_issue_stage.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/operand_issue_stage_if.sv
// Decode/RF/writeback/execute signal bundle for operand_issue_stage.
// The master side is the surrounding pipeline. The slave side is the issue stage.
interface operand_issue_stage_if #(
  parameter int PAYLOAD_W = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [4:0]           in_rs1;
  logic [4:0]           in_rs2;
  logic [4:0]           in_rd;
  logic                 in_rd_wen;
  logic [PAYLOAD_W-1:0] in_payload;
  logic [4:0]           ra1;
  logic [4:0]           ra2;
  logic [31:0]          rd1;
  logic [31:0]          rd2;
  logic                 wb_wen;
  logic [4:0]           wb_wa;
  logic [31:0]          wb_wd;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_rs1_val;
  logic [31:0]          out_rs2_val;
  logic [4:0]           out_rd;
  logic                 out_rd_wen;
  logic [PAYLOAD_W-1:0] out_payload;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rd_wen, in_payload,
    output rd1, rd2, wb_wen, wb_wa, wb_wd, flush, out_ready,
    input  in_ready, ra1, ra2,
    input  out_valid, out_rs1_val, out_rs2_val, out_rd, out_rd_wen, out_payload
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rd_wen, in_payload,
    input  rd1, rd2, wb_wen, wb_wa, wb_wd, flush, out_ready,
    output in_ready, ra1, ra2,
    output out_valid, out_rs1_val, out_rs2_val, out_rd, out_rd_wen, out_payload
  );
endinterface

// File: rtl/operand_issue_stage.sv
// Issue stage: RF read, RAW/WAW scoreboard, one ID/EX slot (1-cycle latency, holds while !out_ready).
// WB_BYPASS_EN forwards the same-cycle writeback to issuing sources instead of stalling a cycle.
module operand_issue_stage #(
  parameter int PAYLOAD_W = 32
) (
  input logic                  clk,
  input logic                  reset,
  operand_issue_stage_if.slave io
);
  logic [31:1]          r_busy;
  logic                 r_out_valid;
  logic [31:0]          r_rs1_val;
  logic [31:0]          r_rs2_val;
  logic [4:0]           r_rd;
  logic                 r_rd_wen;
  logic [PAYLOAD_W-1:0] r_payload;

  logic [31:0] w_busy;
  logic [31:1] w_busy_nxt;
  logic        w_byp1;
  logic        w_byp2;
  logic        w_hazard;
  logic        w_slot_free;
  logic        w_ready;
  logic        w_fire;
  logic [31:0] w_op1;
  logic [31:0] w_op2;

  // x0 never has a pending writer, so bit 0 is hard-wired low
  assign w_busy = {r_busy, 1'b0};

`ifdef WB_BYPASS_EN
  logic w_clr1;
  logic w_clr2;
  assign w_clr1 = io.wb_wen && (io.wb_wa == io.in_rs1) && (io.in_rs1 != 5'd0);
  assign w_clr2 = io.wb_wen && (io.wb_wa == io.in_rs2) && (io.in_rs2 != 5'd0);
  assign w_byp1 = w_clr1;
  assign w_byp2 = w_clr2;
  assign w_op1  = (io.in_rs1 == 5'd0) ? 32'd0 : (w_byp1 ? io.wb_wd : io.rd1);
  assign w_op2  = (io.in_rs2 == 5'd0) ? 32'd0 : (w_byp2 ? io.wb_wd : io.rd2);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
  assign w_op1  = (io.in_rs1 == 5'd0) ? 32'd0 : io.rd1;
  assign w_op2  = (io.in_rs2 == 5'd0) ? 32'd0 : io.rd2;
`endif

  // A destination still owned by an in-flight writer stalls, keeping one writer per register
  assign w_hazard = ((io.in_rs1 != 5'd0) && w_busy[io.in_rs1] && !w_byp1) ||
                    ((io.in_rs2 != 5'd0) && w_busy[io.in_rs2] && !w_byp2) ||
                    (io.in_rd_wen && (io.in_rd != 5'd0) && w_busy[io.in_rd]);

  assign w_slot_free = !r_out_valid || io.out_ready;
  assign w_ready     = w_slot_free && !w_hazard && !io.flush;
  assign w_fire      = io.in_valid && w_ready;

  always_comb begin
    w_busy_nxt = r_busy;
    if (io.wb_wen && (io.wb_wa != 5'd0)) begin
      w_busy_nxt[io.wb_wa] = 1'b0;
    end
    if (io.flush && r_out_valid && r_rd_wen && (r_rd != 5'd0)) begin
      w_busy_nxt[r_rd] = 1'b0;
    end
    // applied last so a new writer wins over a same-cycle writeback
    if (w_fire && io.in_rd_wen && (io.in_rd != 5'd0)) begin
      w_busy_nxt[io.in_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy      <= '0;
      r_out_valid <= 1'b0;
      r_rs1_val   <= '0;
      r_rs2_val   <= '0;
      r_rd        <= '0;
      r_rd_wen    <= 1'b0;
      r_payload   <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (io.flush) begin
        r_out_valid <= 1'b0;
      end else if (w_fire) begin
        r_out_valid <= 1'b1;
        r_rs1_val   <= w_op1;
        r_rs2_val   <= w_op2;
        r_rd        <= io.in_rd;
        r_rd_wen    <= io.in_rd_wen;
        r_payload   <= io.in_payload;
      end else if (io.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign io.in_ready    = w_ready;
  assign io.ra1         = io.in_rs1;
  assign io.ra2         = io.in_rs2;
  assign io.out_valid   = r_out_valid;
  assign io.out_rs1_val = r_rs1_val;
  assign io.out_rs2_val = r_rs2_val;
  assign io.out_rd      = r_rd;
  assign io.out_rd_wen  = r_rd_wen;
  assign io.out_payload = r_payload;
endmodule

// File: tb/tb_operand_issue_stage.sv
// Bench for operand_issue_stage: directed vector table, corner sequences, then random traffic vs a reference model.
// Honours WB_BYPASS_EN the same way the design does.
module tb_operand_issue_stage;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  operand_issue_stage_if #(.PAYLOAD_W(32)) io ();
  operand_issue_stage #(.PAYLOAD_W(32)) dut (.clk(clk), .reset(reset), .io(io.slave));

  logic [31:0] rf [32];
  assign io.rd1 = rf[io.ra1];
  assign io.rd2 = rf[io.ra2];

  int n_pass = 0;
  int n_total = 0;
  logic s_rdy;

  // Reference model: set of registers with a pending writer, plus the ID/EX slot contents
  bit          m_busy [32];
  bit          m_vld;
  logic [31:0] m_v1, m_v2, m_pay;
  logic [4:0]  m_rd;
  bit          m_wen;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  function automatic logic [31:1] busy_vec();
    logic [31:1] b;
    for (int i = 1; i < 32; i++) b[i] = m_busy[i];
    return b;
  endfunction

  function automatic bit wb_hits(input logic [4:0] r);
    return io.wb_wen && (io.wb_wa == r) && (r != 5'd0);
  endfunction

  function automatic bit src_blocked(input logic [4:0] r);
    return (r != 5'd0) && m_busy[r] && !(BYP && wb_hits(r));
  endfunction

  function automatic bit m_ready();
    bit slot_ok;
    bit waw;
    slot_ok = !m_vld || io.out_ready;
    waw = io.in_rd_wen && (io.in_rd != 5'd0) && m_busy[io.in_rd];
    return slot_ok && !io.flush && !waw && !src_blocked(io.in_rs1) && !src_blocked(io.in_rs2);
  endfunction

  function automatic logic [31:0] m_operand(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (BYP && wb_hits(r)) return io.wb_wd;
    return rf[r];
  endfunction

  task automatic drive(input bit v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input bit wen, input bit wbw, input logic [4:0] wa, input logic [31:0] wd,
                       input bit fl, input bit ordy);
    io.in_valid   = v;
    io.in_rs1     = rs1;
    io.in_rs2     = rs2;
    io.in_rd      = rd;
    io.in_rd_wen  = wen;
    io.in_payload = $urandom;
    io.wb_wen     = wbw;
    io.wb_wa      = wa;
    io.wb_wd      = wd;
    io.flush      = fl;
    io.out_ready  = ordy;
  endtask

  // One clock: compare at negedge, advance model, return at posedge+1
  task automatic cyc();
    bit rdy, fire, n_vld, n_wen, wr;
    bit nb [32];
    logic [31:0] n_v1, n_v2, n_pay, wd;
    logic [4:0] n_rd, wa;
    @(negedge clk);
    rdy = m_ready();
    s_rdy = io.in_ready;
    check("in_ready", io.in_ready, rdy);
    check("ra", {io.ra1, io.ra2}, {io.in_rs1, io.in_rs2});
    check("out_valid", io.out_valid, m_vld);
    check("out_bundle", {io.out_rs1_val, io.out_rs2_val, io.out_rd, io.out_rd_wen, io.out_payload},
          {m_v1, m_v2, m_rd, m_wen, m_pay});
    check("busy", dut.r_busy, busy_vec());
    fire = io.in_valid && rdy;
    nb = m_busy;
    if (io.wb_wen && io.wb_wa != 5'd0) nb[io.wb_wa] = 1'b0;
    if (io.flush && m_vld && m_wen && m_rd != 5'd0) nb[m_rd] = 1'b0;
    if (fire && io.in_rd_wen && io.in_rd != 5'd0) nb[io.in_rd] = 1'b1;
    n_vld = m_vld; n_v1 = m_v1; n_v2 = m_v2; n_rd = m_rd; n_wen = m_wen; n_pay = m_pay;
    if (io.flush) n_vld = 1'b0;
    else if (fire) begin
      n_vld = 1'b1;
      n_v1 = m_operand(io.in_rs1);
      n_v2 = m_operand(io.in_rs2);
      n_rd = io.in_rd;
      n_wen = io.in_rd_wen;
      n_pay = io.in_payload;
    end else if (io.out_ready) n_vld = 1'b0;
    wr = io.wb_wen && (io.wb_wa != 5'd0);
    wa = io.wb_wa;
    wd = io.wb_wd;
    @(posedge clk);
    #1;
    m_busy = nb;
    m_vld = n_vld; m_v1 = n_v1; m_v2 = n_v2; m_rd = n_rd; m_wen = n_wen; m_pay = n_pay;
    if (wr) rf[wa] = wd;
  endtask

  typedef struct {
    bit v; logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd; bit wen;
    bit wbw; logic [4:0] wa; logic [31:0] wd; bit ordy;
    bit e_rdy; bit e_ov; logic [31:0] e_v1;
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd5};
    tbl[1] = '{1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd5};
    tbl[2] = tbl[1];
    tbl[3] = tbl[1];
    tbl[4] = '{1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b1, 5'd3, 32'hDEAD, 1'b1,
               BYP, BYP, (BYP ? 32'hDEAD : 32'd5)};
    tbl[5] = '{1'b1, 5'd3, 5'd0, 5'd6, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1, 32'hDEAD};
    tbl[6] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 32'd0};

    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hBAD0_BAD0;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_vld = 1'b0; m_v1 = '0; m_v2 = '0; m_rd = '0; m_wen = 1'b0; m_pay = '0;

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_out_valid", io.out_valid, 1'b0);
    check("rst_out_data", {io.out_rs1_val, io.out_rs2_val, io.out_rd, io.out_rd_wen, io.out_payload}, 0);
    check("rst_busy", dut.r_busy, 0);

    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].wen,
            tbl[i].wbw, tbl[i].wa, tbl[i].wd, 1'b0, tbl[i].ordy);
      cyc();
      check($sformatf("tbl%0d_rdy", i), s_rdy, tbl[i].e_rdy);
      check($sformatf("tbl%0d_ov", i), io.out_valid, tbl[i].e_ov);
      check($sformatf("tbl%0d_v1", i), io.out_rs1_val, tbl[i].e_v1);
      if (i == 0) check("busy_x3", dut.r_busy[3], 1'b1);
    end

    // Backpressure: slot held for 4 cycles, then drain and refill in the same cycle
    drive(1, 1, 2, 8, 1, 0, 0, 0, 0, 1);
    cyc();
    for (int k = 0; k < 4; k++) begin
      drive(1, 2, 1, 9, 1, 0, 0, 0, 0, 0);
      cyc();
      check("hold_rdy", s_rdy, 1'b0);
      check("hold_ov", io.out_valid, 1'b1);
      check("hold_rd", io.out_rd, 5'd8);
      check("hold_v1", io.out_rs1_val, 32'd5);
    end
    drive(1, 2, 1, 9, 1, 0, 0, 0, 0, 1);
    cyc();
    check("b2b_rdy", s_rdy, 1'b1);
    check("b2b_ov", io.out_valid, 1'b1);
    check("b2b_rd", io.out_rd, 5'd9);
    check("b2b_v1", io.out_rs1_val, 32'd7);

    // Flush of a slot holding a writer of x5
    drive(1, 1, 1, 5, 1, 0, 0, 0, 0, 1);
    cyc();
    check("x5_busy", dut.r_busy[5], 1'b1);
    drive(1, 2, 2, 10, 1, 0, 0, 0, 1, 0);
    cyc();
    check("flush_rdy", s_rdy, 1'b0);
    check("flush_ov", io.out_valid, 1'b0);
    check("flush_x5", dut.r_busy[5], 1'b0);
    check("flush_x10", dut.r_busy[10], 1'b0);

    // New writer of x7 coincident with a writeback to x7
    check("x7_pre", dut.r_busy[7], 1'b0);
    drive(1, 0, 0, 7, 1, 1, 7, 32'h123, 0, 1);
    cyc();
    check("x7_set_wins", dut.r_busy[7], 1'b1);

    for (int c = 0; c < 800; c++) begin
      drive($urandom_range(0, 3) != 0,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 3) != 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
